mem_acc: RTL and testbench
==========================

# mem_acc

Data-memory access stage (load/store unit) sitting directly upstream of the write-back mux. It takes a decoded LD/ST opcode, ALU-computed address and store data, runs a req/ack transaction on the data-memory port, and aligns/extends load data. It returns load data plus a one-cycle valid pulse, which the write-back mux uses as its write enable for loads, and stalls the pipeline while a transaction is outstanding.

## Interface
- TIMEOUT_CYC, 64, max cycles `dm_req_o` is held without `dm_ack_i` before the access is aborted.
- clk  in  1  clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  instruction valid in the MEM stage this cycle.
- opcode_i  in  6  opcode; opcat = opcode_i[5:2]; size = opcode_i[1:0].
- addr_i  in  32  byte address from the ALU.
- wdata_i  in  32  store data (rt value).
- mem_o  out  32  aligned/extended load data.
- mem_valid_o  out  1  1-cycle pulse on access completion.
- busy_o  out  1  pipeline stall request.
- err_o  out  1  1-cycle pulse on misalignment or timeout.
- dm_req_o  out  1  memory request; held until ack.
- dm_we_o  out  1  1 = store.
- dm_addr_o  out  32  word address, {addr[31:2],2'b00}.
- dm_be_o  out  4  byte enables.
- dm_wdata_o  out  32  lane-replicated store data.
- dm_ack_i  in  1  memory accepted the request; rdata is valid in the same cycle.
- dm_rdata_i  in  32  read word.

## Operation
- Size code: 00 = word, 01 = half signed, 10 = byte signed, 11 = byte unsigned. For stores, 10 and 11 both mean byte.
- Memory is little-endian; the lane is addr[1:0].
- Misaligned access:
  - Word with addr[1:0]≠0, or half with addr[0]=1.
  - No bus cycle; `err_o` pulses the next cycle; `mem_valid_o` stays 0; `busy_o` stays 0.
- FSM states: IDLE, REQ, DONE.
  - IDLE → REQ: `start_i` with opcat LD or ST, and aligned. Latch we, be, word address, wdata, size, and addr[1:0].
  - REQ: `dm_req_o`=1 with outputs stable.
  - REQ → DONE: on `dm_ack_i`. For loads, `mem_o` is registered from `dm_rdata_i` via the aligner.
  - REQ → IDLE: timeout counter reaches TIMEOUT_CYC. Drop req, pulse `err_o`, no valid.
  - DONE: `mem_valid_o`=1 for exactly 1 cycle (loads and stores), then IDLE. A new start is accepted in DONE, giving back-to-back accesses.
- Load extract: the word lane, the half at addr[1], or the byte at addr[1:0]. Sign- or zero-extend per size.
- `mem_o` holds its value until the next load completes.
- Store byte enables:
  - word: 1111
  - half: 0011<<(2·addr[1])
  - byte: 0001<<addr[1:0]
- Store data replication: `dm_wdata_o` = {4{byte}}, {2{half}}, or the word.
- `start_i` with any other opcat is ignored; `busy_o`=0.
- `start_i` while in REQ is ignored; upstream holds the instruction because `busy_o`=1.
- `dm_ack_i` in IDLE or DONE is ignored.

## Timing
- Reset values:
  - state IDLE
  - `dm_req_o`=0, `dm_we_o`=0
  - `dm_be_o`=0, `dm_addr_o`=0, `dm_wdata_o`=0
  - `mem_o`=0, `mem_valid_o`=0, `err_o`=0
  - timeout counter 0
- Reset in REQ: `dm_req_o` falls at that edge and the transaction is abandoned.
- Latency with a zero-wait memory: start sampled at cycle 0, req at cycle 1 with ack at cycle 1, `mem_valid_o` at cycle 2. Each wait cycle adds one.
- `busy_o` is combinational:
  - 1 when state is REQ.
  - 1 when state is IDLE or DONE and an aligned LD/ST `start_i` is present.
  - 0 otherwise, so it is 0 in the DONE cycle when no new start is present.
- Timeout counter:
  - Width $clog2(TIMEOUT_CYC+1).
  - Cleared on entry to REQ; increments each REQ cycle without ack.
  - Abort when the count = TIMEOUT_CYC−1 with no ack, i.e. after exactly TIMEOUT_CYC req cycles.
  - Ack in that final cycle wins over timeout.

## Structure
- New opcat constant INSTR_OPCAT_ST and the LD/ST size codes go into instructions.v. INSTR_OPCAT_LD already lives there.
- One combinational sub-module, `ld_align`: (rdata, addr[1:0], size) → 32-bit extended data.
- FSM, counter and byte-enable generation stay in `mem_acc`.

## Test plan
- LW at addr 0x100; ack in the first req cycle with rdata 0xDEADBEEF → `dm_be_o`=1111, `mem_o`=0xDEADBEEF, `mem_valid_o` pulses at cycle 2, `busy_o` high in cycle 0 and 1 only.
- LB at 0x103 and LBU at 0x103, rdata 0x80112233 → 0xFFFFFF80 and 0x00000080. LH at 0x102 → 0xFFFF8011.
- SH at 0x102, wdata 0x0000ABCD, 3 wait cycles → `dm_be_o`=1100, `dm_wdata_o`=0xABCDABCD, `dm_we_o`=1, `mem_valid_o` at cycle 5.
- LW at 0x101 → no `dm_req_o`, `err_o` pulse, `mem_valid_o` 0, `busy_o` 0.
- Access never acked, TIMEOUT_CYC=64 → req high exactly 64 cycles, `err_o` pulse, no valid. Repeat with ack in cycle 64 → completes normally.
- `rst` asserted in the 2nd wait cycle of a load → `dm_req_o` 0 after the edge. A later stray ack produces no valid. The next LW completes normally.

Source files
------------

// File: rtl/mem_acc_pkg.sv
// Shared opcode encodings, FSM state type and lane helpers for the load/store unit.
package mem_acc_pkg;

    localparam int unsigned XLEN = 32;

    // Opcode categories (opcode[5:2]) handled by the MEM stage
    localparam logic [3:0] INSTR_OPCAT_LD = 4'b1000;
    localparam logic [3:0] INSTR_OPCAT_ST = 4'b1001;

    // Access size codes (opcode[1:0]); stores treat SIZE_B and SIZE_BU alike
    localparam logic [1:0] SIZE_W  = 2'b00;
    localparam logic [1:0] SIZE_H  = 2'b01;
    localparam logic [1:0] SIZE_B  = 2'b10;
    localparam logic [1:0] SIZE_BU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Byte enables for an access of the given size at byte lane
    function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SIZE_W:  return 4'b1111;
            SIZE_H:  return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b0001 << lane;
        endcase
    endfunction

    // Store data replicated across every lane the access could target
    function automatic logic [XLEN-1:0] repl_wdata(input logic [1:0] size, input logic [XLEN-1:0] wdata);
        case (size)
            SIZE_W:  return wdata;
            SIZE_H:  return {2{wdata[15:0]}};
            default: return {4{wdata[7:0]}};
        endcase
    endfunction

    // Words must sit on a 4-byte boundary, halves on a 2-byte boundary
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        return ((size == SIZE_W) && (lane != 2'b00)) || ((size == SIZE_H) && lane[0]);
    endfunction

endpackage

// File: rtl/mem_acc_ld_align.sv
// Load aligner: selects the addressed lane of the read word and extends it.
module mem_acc_ld_align
    import mem_acc_pkg::*;
(
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_lane,
    input  logic [1:0]      i_size,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select then sign/zero extension by size code
    always_comb begin
        w_byte = 8'h00;
        w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_lane)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        case (i_size)
            SIZE_W:  o_data = i_rdata;
            SIZE_H:  o_data = {{16{w_half[15]}}, w_half};
            SIZE_B:  o_data = {{24{w_byte[7]}}, w_byte};
            default: o_data = {24'h000000, w_byte};
        endcase
    end

endmodule

// File: rtl/mem_acc.sv
// Data-memory access stage: req/ack bus transaction, byte lanes, load alignment.
module mem_acc
    import mem_acc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [5:0]      opcode_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] mem_o,
    output logic            mem_valid_o,
    output logic            busy_o,
    output logic            err_o,
    output logic            dm_req_o,
    output logic            dm_we_o,
    output logic [XLEN-1:0] dm_addr_o,
    output logic [3:0]      dm_be_o,
    output logic [XLEN-1:0] dm_wdata_o,
    input  logic            dm_ack_i,
    input  logic [XLEN-1:0] dm_rdata_i
);

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_size;
    logic [1:0]        r_lane;
    logic [XLEN-1:0]   r_mem;
    logic              r_valid;
    logic              r_err;
    logic              r_req;
    logic              r_we;
    logic [XLEN-1:0]   r_addr;
    logic [3:0]        r_be;
    logic [XLEN-1:0]   r_wdata;

    logic [3:0]        w_opcat;
    logic [1:0]        w_size;
    logic [1:0]        w_lane;
    logic              w_is_st;
    logic              w_ldst;
    logic              w_mis;
    logic              w_can_start;
    logic              w_accept;
    logic              w_mis_start;
    logic [XLEN-1:0]   w_align;

    // Decode of the instruction presented this cycle
    assign w_opcat     = opcode_i[5:2];
    assign w_size      = opcode_i[1:0];
    assign w_lane      = addr_i[1:0];
    assign w_is_st     = (w_opcat == INSTR_OPCAT_ST);
    assign w_ldst      = w_is_st || (w_opcat == INSTR_OPCAT_LD);
    assign w_mis       = is_misaligned(w_size, w_lane);
    assign w_can_start = (r_state != ST_REQ);
    assign w_accept    = start_i && w_ldst && !w_mis && w_can_start;
    assign w_mis_start = start_i && w_ldst && w_mis && w_can_start;

    // Stall while a transaction is in flight or about to launch
    assign busy_o = (r_state == ST_REQ) || w_accept;

    assign mem_o       = r_mem;
    assign mem_valid_o = r_valid;
    assign err_o       = r_err;
    assign dm_req_o    = r_req;
    assign dm_we_o     = r_we;
    assign dm_addr_o   = r_addr;
    assign dm_be_o     = r_be;
    assign dm_wdata_o  = r_wdata;

    mem_acc_ld_align u_ld_align (
        .i_rdata (dm_rdata_i),
        .i_lane  (r_lane),
        .i_size  (r_size),
        .o_data  (w_align)
    );

    // Transaction FSM with timeout counter and registered bus/result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_size  <= 2'b00;
            r_lane  <= 2'b00;
            r_mem   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= 4'b0000;
            r_wdata <= '0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_state <= ST_REQ;
                        r_req   <= 1'b1;
                        r_we    <= w_is_st;
                        r_addr  <= {addr_i[31:2], 2'b00};
                        r_be    <= calc_be(w_size, w_lane);
                        r_wdata <= repl_wdata(w_size, wdata_i);
                        r_size  <= w_size;
                        r_lane  <= w_lane;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_err   <= w_mis_start;
                    end
                end
                ST_REQ: begin
                    // An ack on the last allowed cycle beats the timeout
                    if (dm_ack_i) begin
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= ST_DONE;
                        if (!r_we) begin
                            r_mem <= w_align;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_acc.sv
// Randomized scoreboard bench for mem_acc with a byte-level memory reference model.
module tb_mem_acc;
    import mem_acc_pkg::*;

    localparam int unsigned TO   = 64;
    localparam int unsigned BASE = 32'h100;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [5:0]  opcode_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] mem_o;
    logic        mem_valid_o;
    logic        busy_o;
    logic        err_o;
    logic        dm_req_o;
    logic        dm_we_o;
    logic [31:0] dm_addr_o;
    logic [3:0]  dm_be_o;
    logic [31:0] dm_wdata_o;
    logic        dm_ack_i;
    logic [31:0] dm_rdata_i;

    mem_acc #(.TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .opcode_i   (opcode_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .mem_o      (mem_o),
        .mem_valid_o(mem_valid_o),
        .busy_o     (busy_o),
        .err_o      (err_o),
        .dm_req_o   (dm_req_o),
        .dm_we_o    (dm_we_o),
        .dm_addr_o  (dm_addr_o),
        .dm_be_o    (dm_be_o),
        .dm_wdata_o (dm_wdata_o),
        .dm_ack_i   (dm_ack_i),
        .dm_rdata_i (dm_rdata_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        int          when;
        logic [31:0] mem;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] word_mem [16];
    logic [7:0]  ref_mem  [64];
    logic [31:0] last_load;

    int          rsp_delay  = 0;
    bit          rsp_ack_en = 1'b0;
    bit          stray_en   = 1'b0;
    int          wait_cnt   = 0;
    logic [31:0] exp_addr;
    bit          exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic int nbytes(input logic [1:0] size);
        if (size == SIZE_W) return 4;
        if (size == SIZE_H) return 2;
        return 1;
    endfunction

    // Little-endian read of n bytes from the reference memory, then extension
    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size);
        logic [31:0] v;
        int n;
        int off;
        n   = nbytes(size);
        off = int'(addr - BASE);
        v   = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[off + i]) << (8 * i));
        if (size == SIZE_H && v[15]) v = v | 32'hFFFF0000;
        if (size == SIZE_B && v[7])  v = v | 32'hFFFFFF00;
        return v;
    endfunction

    function automatic void ref_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd);
        int n;
        int off;
        n   = nbytes(size);
        off = int'(addr - BASE);
        for (int i = 0; i < n; i++) ref_mem[off + i] = wd[8*i +: 8];
    endfunction

    function automatic void poke_word(input int idx, input logic [31:0] val);
        word_mem[idx] = val;
        for (int b = 0; b < 4; b++) ref_mem[4*idx + b] = val[8*b +: 8];
    endfunction

    // Memory responder: acks after rsp_delay wait cycles, optional stray acks when idle
    always @(negedge clk) begin
        if (dm_req_o) begin
            if (rsp_ack_en && wait_cnt == rsp_delay) begin
                dm_ack_i = 1'b1;
                check("bus_addr", dm_addr_o, exp_addr);
                check("bus_we", 32'(dm_we_o), 32'(exp_we));
                check("bus_be", 32'(dm_be_o), 32'(exp_be));
                if (exp_we) check("bus_wdata", dm_wdata_o, exp_wdata);
                if (dm_we_o) begin
                    for (int b = 0; b < 4; b++)
                        if (dm_be_o[b]) word_mem[dm_addr_o[5:2]][8*b +: 8] = dm_wdata_o[8*b +: 8];
                    dm_rdata_i = $urandom;
                end else begin
                    dm_rdata_i = word_mem[dm_addr_o[5:2]];
                end
            end else begin
                dm_ack_i   = 1'b0;
                dm_rdata_i = $urandom;
            end
            wait_cnt++;
        end else begin
            wait_cnt   = 0;
            dm_ack_i   = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
            dm_rdata_i = $urandom;
        end
    end

    // Scoreboard monitor: every valid/err pulse must match the next expectation
    always @(negedge clk) begin
        if (!rst && (mem_valid_o || err_o)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: valid=%b err=%b at cycle %0d, none expected",
                         mem_valid_o, err_o, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_kind", {30'h0, mem_valid_o, err_o}, mon_e.is_err ? 32'd1 : 32'd2);
                check("pulse_cycle", 32'(cyc), 32'(mon_e.when));
                check("mem_o", mem_o, mon_e.mem);
            end
        end
    end

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            start_i = 1'b0;
            @(negedge clk);
            check("idle_busy", 32'(busy_o), 32'd0);
            check("idle_req", 32'(dm_req_o), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    // Issue one instruction at the current cycle and follow it until the stage frees up
    task automatic run_txn(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                           input int dly, input bit ack_en, input bit noise);
        logic [3:0]  opcat;
        logic [1:0]  size;
        logic [3:0]  be;
        logic [31:0] wl;
        bit          st;
        bit          ldst;
        bit          mis;
        int          n;
        int          t;
        int          reqc;
        opcat = op[5:2];
        size  = op[1:0];
        st    = (opcat == INSTR_OPCAT_ST);
        ldst  = st || (opcat == INSTR_OPCAT_LD);
        n     = nbytes(size);
        mis   = (int'(addr) % n) != 0;
        t     = cyc;
        reqc  = 0;
        start_i  = 1'b1;
        opcode_i = op;
        addr_i   = addr;
        wdata_i  = wd;
        if (ldst && mis) begin
            exp_q.push_back('{1'b1, t + 1, last_load});
        end else if (ldst) begin
            be = 4'b0000;
            for (int i = 0; i < n; i++) be[int'(addr % 4) + i] = 1'b1;
            for (int ln = 0; ln < 4; ln++) wl[8*ln +: 8] = wd[8*(ln % n) +: 8];
            exp_addr   = addr & 32'hFFFFFFFC;
            exp_we     = st;
            exp_be     = be;
            exp_wdata  = wl;
            rsp_delay  = dly;
            rsp_ack_en = ack_en;
            if (!ack_en) begin
                reqc = TO;
                exp_q.push_back('{1'b1, t + 1 + TO, last_load});
            end else begin
                reqc = dly + 1;
                if (st) ref_store(addr, size, wd);
                else    last_load = ref_load(addr, size);
                exp_q.push_back('{1'b0, t + 2 + dly, last_load});
            end
        end
        @(negedge clk);
        check("start_busy", 32'(busy_o), 32'(ldst && !mis));
        check("start_req", 32'(dm_req_o), 32'd0);
        @(posedge clk); #1;
        for (int c = 0; c < reqc; c++) begin
            if (noise) begin
                start_i  = 1'($urandom_range(0, 1));
                opcode_i = 6'($urandom);
                addr_i   = $urandom;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk);
            check("req_busy", 32'(busy_o), 32'd1);
            check("req_high", 32'(dm_req_o), 32'd1);
            @(posedge clk); #1;
        end
        start_i = 1'b0;
    endtask

    function automatic logic [5:0] rand_op();
        logic [3:0] oc;
        int r;
        r = $urandom_range(0, 7);
        if (r < 3)      oc = INSTR_OPCAT_LD;
        else if (r < 6) oc = INSTR_OPCAT_ST;
        else            oc = 4'($urandom);
        return {oc, 2'($urandom)};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1);
    end

    initial begin
        int dly;
        bit ack_en;
        rst      = 1'b1;
        start_i  = 1'b0;
        opcode_i = 6'h0;
        addr_i   = 32'h0;
        wdata_i  = 32'h0;
        last_load = 32'h0;
        for (int i = 0; i < 16; i++) poke_word(i, $urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req", 32'(dm_req_o), 32'd0);
        check("rst_we", 32'(dm_we_o), 32'd0);
        check("rst_be", 32'(dm_be_o), 32'd0);
        check("rst_addr", dm_addr_o, 32'd0);
        check("rst_wdata", dm_wdata_o, 32'd0);
        check("rst_mem", mem_o, 32'd0);
        check("rst_valid", 32'(mem_valid_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // LW 0x100, zero-wait
        poke_word(0, 32'hDEADBEEF);
        run_txn({INSTR_OPCAT_LD, SIZE_W}, 32'h100, 32'h0, 0, 1'b1, 1'b0);
        check("lw_be", 32'(dm_be_o), 32'hF);
        check("lw_data", mem_o, 32'hDEADBEEF);
        idle(2);

        // Byte/half extension from 0x80112233
        poke_word(0, 32'h80112233);
        run_txn({INSTR_OPCAT_LD, SIZE_B}, 32'h103, 32'h0, 0, 1'b1, 1'b0);
        check("lb_data", mem_o, 32'hFFFFFF80);
        run_txn({INSTR_OPCAT_LD, SIZE_BU}, 32'h103, 32'h0, 1, 1'b1, 1'b0);
        check("lbu_data", mem_o, 32'h00000080);
        run_txn({INSTR_OPCAT_LD, SIZE_H}, 32'h102, 32'h0, 0, 1'b1, 1'b0);
        check("lh_data", mem_o, 32'hFFFF8011);
        idle(1);

        // SH 0x102 with 3 wait cycles
        run_txn({INSTR_OPCAT_ST, SIZE_H}, 32'h102, 32'h0000ABCD, 3, 1'b1, 1'b1);
        check("sh_be", 32'(dm_be_o), 32'hC);
        check("sh_wdata", dm_wdata_o, 32'hABCDABCD);
        check("sh_we", 32'(dm_we_o), 32'd1);
        idle(1);

        // Misaligned LW
        run_txn({INSTR_OPCAT_LD, SIZE_W}, 32'h101, 32'h0, 0, 1'b1, 1'b0);
        idle(2);

        // Timeout, then ack on the final allowed cycle
        run_txn({INSTR_OPCAT_LD, SIZE_W}, 32'h104, 32'h0, 0, 1'b0, 1'b0);
        idle(2);
        run_txn({INSTR_OPCAT_LD, SIZE_W}, 32'h104, 32'h0, TO - 1, 1'b1, 1'b0);
        idle(2);

        // Reset in the second wait cycle of a load
        rsp_ack_en = 1'b0;
        start_i  = 1'b1;
        opcode_i = {INSTR_OPCAT_LD, SIZE_W};
        addr_i   = 32'h108;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rstreq_before", 32'(dm_req_o), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstreq_req", 32'(dm_req_o), 32'd0);
        check("rstreq_mem", mem_o, 32'd0);
        last_load = 32'h0;
        @(posedge clk); #1;
        stray_en = 1'b1;
        idle(6);
        run_txn({INSTR_OPCAT_LD, SIZE_W}, 32'h108, 32'h0, 2, 1'b1, 1'b0);
        idle(2);

        // Randomized traffic with back-to-back issue, noise during REQ and stray acks
        for (int k = 0; k < 300; k++) begin
            ack_en = ($urandom_range(0, 39) != 0);
            dly    = ($urandom_range(0, 19) == 0) ? TO - 1 : $urandom_range(0, 5);
            run_txn(rand_op(), BASE + $urandom_range(0, 63), $urandom, dly, ack_en,
                    1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
        end
        stray_en = 1'b0;
        idle(4);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
